// File: rtl/tuner_note_map_if.sv
// rtl/tuner_note_map_if.sv - peak-in / note-out bus for the tuner note mapper
interface tuner_note_map_if;
  logic        peak_valid;
  logic [9:0]  peak_bin;
  logic        busy;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic [10:0] offset;
  logic [1:0]  tune_state;
  logic        overrun;

  modport master (
    output peak_valid, peak_bin,
    input  busy, note_valid, note_idx, offset, tune_state, overrun
  );

  modport slave (
    input  peak_valid, peak_bin,
    output busy, note_valid, note_idx, offset, tune_state, overrun
  );
endinterface

// File: rtl/tuner_note_map.sv
// rtl/tuner_note_map.sv - nearest guitar-string note lookup for a peak FFT bin (optional TUNER_HYST_EN)
module tuner_note_map #(
  parameter int TOL      = 2,
  parameter int MAX_DIST = 40,
  parameter int MIN_BIN  = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  tuner_note_map_if.slave bus
);

  localparam logic [10:0] TOL_W      = 11'(TOL);
  localparam logic [10:0] MAX_DIST_W = 11'(MAX_DIST);
  localparam logic [10:0] MIN_BIN_W  = 11'(MIN_BIN);

  typedef enum logic [1:0] {IDLE, SCAN, CLASSIFY, DONE} state_t;

  state_t      state, state_nxt;
  logic        start, scan_step, classify, publish;
  logic [9:0]  bin_q;
  logic [10:0] best_dist;
  logic [2:0]  best_idx;
  logic [2:0]  idx;
  logic [2:0]  res_idx;
  logic [10:0] res_off;
  logic [1:0]  res_state;
  logic        res_pub;

  // Centre bins of the six open strings; 1 Hz per bin so these are in Hz.
  function automatic logic signed [10:0] centre(input logic [2:0] k);
    case (k)
      3'd0:    centre = 11'sd82;
      3'd1:    centre = 11'sd110;
      3'd2:    centre = 11'sd147;
      3'd3:    centre = 11'sd196;
      3'd4:    centre = 11'sd247;
      default: centre = 11'sd330;
    endcase
  endfunction

  logic signed [10:0] scan_diff;
  logic [10:0]        scan_dist;
  logic signed [10:0] cls_off;
  logic [10:0]        cls_abs;
  logic               cls_nonote;
  logic [1:0]         cls_state;
  logic               cls_pub;

  assign scan_diff  = $signed({1'b0, bin_q}) - centre(idx);
  assign scan_dist  = scan_diff[10] ? 11'(-scan_diff) : scan_diff;
  assign cls_off    = $signed({1'b0, bin_q}) - centre(best_idx);
  assign cls_abs    = cls_off[10] ? 11'(-cls_off) : cls_off;
  assign cls_nonote = ({1'b0, bin_q} < MIN_BIN_W) || (best_dist > MAX_DIST_W);

  // Verdict for the display: no-note wins, then in-tune window, then sign.
  always_comb begin
    cls_state = 2'b11;
    if (cls_nonote)            cls_state = 2'b11;
    else if (cls_abs <= TOL_W) cls_state = 2'b00;
    else if (cls_off[10])      cls_state = 2'b01;
    else                       cls_state = 2'b10;
  end

`ifdef TUNER_HYST_EN
  logic [2:0] cand;
  logic [2:0] cls_cand;

  assign cls_cand = cls_nonote ? 3'd7 : best_idx;
  assign cls_pub  = (cls_cand == cand);

  // Previous frame's note (7 = no-note); a result is only shown once it repeats.
  always_ff @(posedge clk) begin
    if (!rst_n)        cand <= 3'd7;
    else if (classify) cand <= cls_cand;
  end
`else
  assign cls_pub = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    scan_step = 1'b0;
    classify  = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.peak_valid) begin
          start     = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        scan_step = 1'b1;
        if (idx == 3'd5) state_nxt = CLASSIFY;
      end
      CLASSIFY: begin
        classify  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: latch the bin, walk the table, keep the closest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q     <= '0;
      best_dist <= 11'd1023;
      best_idx  <= '0;
      idx       <= '0;
      res_idx   <= '0;
      res_off   <= '0;
      res_state <= 2'b11;
      res_pub   <= 1'b0;
    end else begin
      if (start) begin
        bin_q     <= bus.peak_bin;
        best_dist <= 11'd1023;
        best_idx  <= '0;
        idx       <= '0;
      end
      if (scan_step) begin
        if (scan_dist < best_dist) begin
          best_dist <= scan_dist;
          best_idx  <= idx;
        end
        idx <= idx + 3'd1;
      end
      if (classify) begin
        res_idx   <= best_idx;
        res_off   <= cls_off;
        res_state <= cls_state;
        res_pub   <= cls_pub;
      end
    end
  end

  // Registered outputs; busy lags the state by one edge so it covers cycles 1..8.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.note_idx   <= '0;
      bus.offset     <= '0;
      bus.tune_state <= 2'b11;
      bus.note_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.busy       <= (state != IDLE);
      bus.note_valid <= publish && res_pub;
      if (bus.peak_valid && (state != IDLE)) bus.overrun <= 1'b1;
      if (publish && res_pub) begin
        bus.note_idx   <= res_idx;
        bus.offset     <= res_off;
        bus.tune_state <= res_state;
      end
    end
  end

endmodule

// File: tb/tb_tuner_note_map.sv
// tb/tb_tuner_note_map.sv - directed self-checking bench for tuner_note_map
module tb_tuner_note_map;

  logic clk;
  logic rst_n;

  tuner_note_map_if bus();

  tuner_note_map dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of what the outputs should currently show.
  int m_cand = 7;
  int m_idx  = 0;
  int m_off  = 0;
  int m_st   = 3;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_pub(input int c);
`ifdef TUNER_HYST_EN
    bit p;
    p = (c == m_cand);
    m_cand = c;
    return p;
`else
    return (c >= 0);
`endif
  endfunction

  task automatic model_reset();
    m_cand = 7;
    m_idx  = 0;
    m_off  = 0;
    m_st   = 3;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_idx"}, int'(bus.note_idx), m_idx);
    check({tag, "_off"}, int'($signed(bus.offset)), m_off);
    check({tag, "_st"},  int'(bus.tune_state), m_st);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.peak_valid = 1'b0;
    bus.peak_bin = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One lookup from idle; checks latency, busy window, hold before publish and the result.
  task automatic lookup(input int bin, input int e_idx, input int e_off, input int e_st);
    int nv_at, nv_n, busy_mask;
    int pre_idx, pre_off, pre_st;
    bit pub;
    string tag;
    tag = $sformatf("bin%0d", bin);
    pub = model_pub(e_st == 3 ? 7 : e_idx);
    nv_at = -1; nv_n = 0; busy_mask = 0;
    pre_idx = 0; pre_off = 0; pre_st = 0;
    bus.peak_valid = 1'b1;
    bus.peak_bin = 10'(bin);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      bus.peak_valid = 1'b0;
      if (bus.busy) busy_mask |= (1 << k);
      if (bus.note_valid) begin
        nv_n++;
        nv_at = k;
      end
      if (k == 7) begin
        pre_idx = int'(bus.note_idx);
        pre_off = int'($signed(bus.offset));
        pre_st  = int'(bus.tune_state);
      end
    end
    check({tag, "_hold_idx"}, pre_idx, m_idx);
    check({tag, "_hold_off"}, pre_off, m_off);
    check({tag, "_hold_st"},  pre_st,  m_st);
    if (pub) begin
      m_idx = e_idx;
      m_off = e_off;
      m_st  = e_st;
    end
    check({tag, "_nv_at"}, nv_at, pub ? 8 : -1);
    check({tag, "_nv_n"}, nv_n, pub ? 1 : 0);
    check({tag, "_busy"}, busy_mask, 32'h1FE);
    check_outputs(tag);
  endtask

  // Peak pulses scheduled per edge for the overrun sequence.
  function automatic bit ov_pv(input int e);
    return (e == 0) || (e == 3) || (e == 8) || (e == 9);
  endfunction

  function automatic int ov_bin(input int e);
    case (e)
      0:       return 110;
      3:       return 330;
      8:       return 196;
      default: return 247;
    endcase
  endfunction

  initial begin
    int nv_mask, busy_mask, nv_n;
    bit pub1, pub2;
    rst_n = 1'b0;
    bus.peak_valid = 1'b0;
    bus.peak_bin = '0;
    @(negedge clk);
    do_reset();

    check("rst_nv",   int'(bus.note_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ovr",  int'(bus.overrun), 0);
    check_outputs("rst");

    lookup(110, 1,   0, 0);
    lookup(150, 2,   3, 2);
    lookup(144, 2,  -3, 1);
    lookup(96,  0,  14, 2);
    lookup(30,  0, -52, 3);
    lookup(59,  0, -23, 3);
    lookup(60,  0, -22, 1);
    lookup(112, 1,   2, 0);
    lookup(113, 1,   3, 2);
    lookup(108, 1,  -2, 0);
    lookup(370, 5,  40, 2);
    lookup(371, 5,  41, 3);
    lookup(511, 5, 181, 3);
    check("ovr_clean", int'(bus.overrun), 0);

    do_reset();
    lookup(110, 1, 0, 0);
    lookup(147, 2, 0, 0);
    lookup(147, 2, 0, 0);

    do_reset();
    pub1 = model_pub(1);
    nv_mask = 0; busy_mask = 0;
    bus.peak_valid = ov_pv(0);
    bus.peak_bin = 10'(ov_bin(0));
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_mask |= (1 << k);
      if (bus.note_valid) nv_mask |= (1 << k);
      if (k == 2) check("ovr_before", int'(bus.overrun), 0);
      if (k == 3) check("ovr_set", int'(bus.overrun), 1);
      if (k == 8) begin
        if (pub1) begin
          m_idx = 1; m_off = 0; m_st = 0;
        end
        pub2 = model_pub(4);
        check_outputs("ovr_first");
      end
      bus.peak_valid = ov_pv(k + 1);
      bus.peak_bin = 10'(ov_bin(k + 1));
    end
    if (pub2) begin
      m_idx = 4; m_off = 0; m_st = 0;
    end
    check("ovr_nv_mask", nv_mask, (int'(pub1) << 8) | (int'(pub2) << 17));
    check("ovr_busy_mask", busy_mask, 32'h3FDFE);
    check("ovr_sticky", int'(bus.overrun), 1);
    check_outputs("ovr_second");

    nv_n = 0;
    bus.peak_valid = 1'b1;
    bus.peak_bin = 10'd196;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      bus.peak_valid = 1'b0;
      if (bus.note_valid) nv_n++;
      if (k == 3) rst_n = 1'b0;
      if (k == 4) begin
        rst_n = 1'b1;
        model_reset();
      end
    end
    check("midrst_nv", nv_n, 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ovr", int'(bus.overrun), 0);
    check_outputs("midrst");

    lookup(247, 4, 0, 0);
`ifdef TUNER_HYST_EN
    lookup(247, 4, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tuner_note_map.md
# tuner_note_map

Downstream stage of the spectral peak finder. Accepts the winning FFT bin index, one pulse per spectrum frame, and finds the nearest guitar string note by scanning a fixed 6-entry note table, one entry per cycle. Emits the note index, the signed bin offset from that note's centre, and a flat/in-tune/sharp/no-note verdict for the display driver. Bin resolution is 1 Hz/bin, so a bin number equals its frequency in Hz.

## Interface
Parameters:
- TOL, 2: maximum |offset| in bins that still reports in-tune.
- MAX_DIST, 40: |offset| above this reports no-note.
- MIN_BIN, 60: bins below this report no-note without scanning the result (DC/rumble reject).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- peak_valid  in  1  one-cycle pulse; peak_bin is valid.
- peak_bin  in  10  unsigned peak bin index, 0..511.
- busy  out  1  high while a lookup is in progress.
- note_valid  out  1  one-cycle pulse; result outputs updated.
- note_idx  out  3  0=E2, 1=A2, 2=D3, 3=G3, 4=B3, 5=E4.
- offset  out  11  signed, peak_bin minus the nearest note's centre bin.
- tune_state  out  2  00 in-tune, 01 flat, 10 sharp, 11 no-note.
- overrun  out  1  sticky; a peak_valid arrived while busy.

## Operation
- Note centre bins, fixed: 82, 110, 147, 196, 247, 330.
- FSM states: IDLE, SCAN, CLASSIFY, DONE.
- IDLE:
  - On peak_valid, latch peak_bin.
  - Clear the scan registers: best_dist=1023, best_idx=0, i=0.
  - Go to SCAN.
- SCAN: once per cycle, compute d=|bin−c[i]| with 11-bit signed arithmetic.
  - If d < best_dist (strict), store best_dist=d and best_idx=i. Ties keep the lower index.
  - Increment i. After i=5, go to CLASSIFY.
- CLASSIFY: form the result.
  - offset = bin − c[best_idx], sign-extended.
  - tune_state = 11 if bin < MIN_BIN or best_dist > MAX_DIST.
  - Otherwise 00 if |offset| ≤ TOL, else 01 if offset < 0, else 10.
  - note_idx and offset are still updated when the verdict is no-note.
- DONE: drive note_valid high for one cycle and return to IDLE.
- busy is high in SCAN, CLASSIFY and DONE.
- A peak_valid outside IDLE is dropped and sets overrun. overrun clears only on reset.
- Reset:
  - Reset takes priority in any state, including mid-scan.
  - The FSM returns to IDLE and the partial result is discarded; no note_valid is issued.
  - Reset values: note_idx=0, offset=0, tune_state=11, note_valid=0, busy=0, overrun=0.

## Timing
- Cycle 0 is the edge that samples peak_valid in IDLE. busy is high from cycle 1.
- SCAN occupies cycles 1–6 and CLASSIFY occupies cycle 7.
- The result outputs and note_valid are registered at edge 8. note_valid is high for that single cycle.
- busy drops at edge 9.
- Result outputs hold their values between updates.
- Throughput: a new peak_valid is accepted from cycle 9 onward. A peak_valid at edge 9 starts a new lookup.
- A peak_valid at the same edge as note_valid is dropped and sets overrun.

## Configuration
- TUNER_HYST_EN defined:
  - A candidate register holds the previous CLASSIFY note, reset to 7. A no-note result counts as candidate 7.
  - Outputs update and note_valid pulses only when the new candidate equals the stored candidate.
  - The candidate register is updated after every CLASSIFY, whether or not the outputs update.
  - Timing of any pulse is unchanged.
- TUNER_HYST_EN undefined: every lookup updates the outputs and pulses note_valid. No candidate register is built.

## Test plan
- Reset, then peak_bin=110 pulse → note_valid exactly 8 cycles later with note_idx=1, offset=0, tune_state=00; busy high for cycles 1–8.
- peak_bin=150 → note_idx=2, offset=+3, tune_state=10; peak_bin=144 → note_idx=2, offset=−3, tune_state=01.
- peak_bin=96 (tie between 82 and 110) → note_idx=0, offset=+14, tune_state=10; peak_bin=30 → tune_state=11.
- Two pulses 3 cycles apart (bins 110, 330) → one result for 110 only, overrun=1. A pulse at cycle 9 is accepted.
- rst_n low at cycle 4 of a lookup → no note_valid, all outputs at reset values. The next pulse (bin 247) → note_idx=4, offset=0.
- TUNER_HYST_EN: bins 110, 147, 147 → no pulse, no pulse, then a pulse with note_idx=2. Without the macro, three pulses.
